// File: rtl/dual_issue_pkg.sv
// Shared definitions for the dual-issue front end: opcode/funct constants,
// scheduler FSM states, buffer geometry, entry/decode structs and decode helpers.
package dual_issue_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned PTR_W     = 2;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned ST_W      = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [ST_W-1:0] ST_RUN      = 2'd0;
    localparam logic [ST_W-1:0] ST_LU_STALL = 2'd1;
    localparam logic [ST_W-1:0] ST_FLUSH    = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } buf_entry_t;

    // dest == 0 means "no destination"
    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src2;
        logic             use1;
        logic             use2;
        logic             is_mem;
        logic             is_ctrl;
    } dec_t;

    // Register usage of one instruction from its opcode and register fields.
    function automatic dec_t decode(input logic [5:0] op, input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rt, input logic [REG_W-1:0] rd);
        dec_t d;
        d = '0;
        case (op)
            OP_RTYPE: begin
                d.dest = rd; d.src1 = rs; d.src2 = rt; d.use1 = 1'b1; d.use2 = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                d.dest = rt; d.src1 = rs; d.use1 = 1'b1;
            end
            OP_LW: begin
                d.dest = rt; d.src1 = rs; d.use1 = 1'b1; d.is_mem = 1'b1;
            end
            OP_SW: begin
                d.src1 = rs; d.src2 = rt; d.use1 = 1'b1; d.use2 = 1'b1; d.is_mem = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                d.src1 = rs; d.src2 = rt; d.use1 = 1'b1; d.use2 = 1'b1; d.is_ctrl = 1'b1;
            end
            OP_J:    d.is_ctrl = 1'b1;
            OP_JAL: begin
                d.is_ctrl = 1'b1; d.dest = 5'd31;
            end
            default: ;
        endcase
        return d;
    endfunction

    // True when a used, nonzero source matches a load destination in either lane.
    function automatic logic lu_blocked(input dec_t d,
                                        input logic m1, input logic [REG_W-1:0] d1,
                                        input logic m2, input logic [REG_W-1:0] d2);
        logic hit1;
        logic hit2;
        hit1 = d.use1 && (d.src1 != '0) && ((m1 && (d.src1 == d1)) || (m2 && (d.src1 == d2)));
        hit2 = d.use2 && (d.src2 != '0) && ((m1 && (d.src2 == d1)) || (m2 && (d.src2 == d2)));
        return hit1 || hit2;
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Fetch / issue / hazard-feedback bundle of the issue scheduler.
// master: fetch + control source and issue sink; slave: the scheduler.
interface issue_scheduler_if;
    import dual_issue_pkg::*;

    logic              fetch_valid0;
    logic              fetch_valid1;
    logic [XLEN-1:0]   fetch_instr0;
    logic [XLEN-1:0]   fetch_instr1;
    logic [XLEN-1:0]   fetch_pc0;
    logic              fetch_ready;
    logic              id_stall;
    logic              flush;
    logic              lu_memread1;
    logic              lu_memread2;
    logic [REG_W-1:0]  lu_dest1;
    logic [REG_W-1:0]  lu_dest2;
    logic              issue_valid1;
    logic              issue_valid2;
    logic [XLEN-1:0]   issue_instr1;
    logic [XLEN-1:0]   issue_instr2;
    logic [XLEN-1:0]   issue_pc1;
    logic [XLEN-1:0]   issue_pc2;

    modport master (
        output fetch_valid0, fetch_valid1, fetch_instr0, fetch_instr1, fetch_pc0,
        output id_stall, flush, lu_memread1, lu_memread2, lu_dest1, lu_dest2,
        input  fetch_ready,
        input  issue_valid1, issue_valid2, issue_instr1, issue_instr2, issue_pc1, issue_pc2
    );

    modport slave (
        input  fetch_valid0, fetch_valid1, fetch_instr0, fetch_instr1, fetch_pc0,
        input  id_stall, flush, lu_memread1, lu_memread2, lu_dest1, lu_dest2,
        output fetch_ready,
        output issue_valid1, issue_valid2, issue_instr1, issue_instr2, issue_pc1, issue_pc2
    );

endinterface

// File: rtl/instr_buffer.sv
// 4-entry circular instruction FIFO, up to two pushes and two pops per cycle.
// Ports: clk, rst (async active-low), clear (drop everything), push_n/wdata0/1,
// pop_n, head0/head1 (oldest two entries), count (registered occupancy).
module instr_buffer
    import dual_issue_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [1:0]       push_n,
    input  buf_entry_t       wdata0,
    input  buf_entry_t       wdata1,
    input  logic [1:0]       pop_n,
    output buf_entry_t       head0,
    output buf_entry_t       head1,
    output logic [CNT_W-1:0] count
);

    buf_entry_t       mem_q [BUF_DEPTH];
    buf_entry_t       mem_d [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_nxt, rd_nxt;
    logic [CNT_W-1:0] count_q, count_d;

    assign wr_nxt = wr_ptr_q + PTR_W'(1);
    assign rd_nxt = rd_ptr_q + PTR_W'(1);
    assign head0  = mem_q[rd_ptr_q];
    assign head1  = mem_q[rd_nxt];
    assign count  = count_q;

    // Pointer/count update; 2-bit pointers wrap naturally
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_n != 2'd0) mem_d[wr_ptr_q] = wdata0;
            if (push_n == 2'd2) mem_d[wr_nxt]   = wdata1;
            wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
            count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: buffers fetched pairs, decodes the two oldest entries,
// resolves load-use and intra-pair hazards and registers up to two issues/cycle.
// Ports: clk, rst (async active-low), bus (issue_scheduler_if.slave: fetch,
// id_stall, flush, load-use feedback in; fetch_ready and issue slots out).
module issue_scheduler
    import dual_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    issue_scheduler_if.slave  bus
);

    logic [ST_W-1:0]  state_q, state_d;
    logic             valid1_q, valid1_d, valid2_q, valid2_d;
    logic [XLEN-1:0]  instr1_q, instr1_d, instr2_q, instr2_d;
    logic [XLEN-1:0]  pc1_q, pc1_d, pc2_q, pc2_d;

    buf_entry_t       head0, head1, wdata0, wdata1;
    logic [CNT_W-1:0] count;
    logic [1:0]       push_n, pop_n;
    logic             clear;
    dec_t             dec0, dec1;
    logic             blk0_c, blk1_c, pair_ok_c, ready_c, slot1_c, slot2_c;

    instr_buffer u_buf (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .push_n (push_n),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .pop_n  (pop_n),
        .head0  (head0),
        .head1  (head1),
        .count  (count)
    );

    assign wdata0 = '{instr: bus.fetch_instr0, pc: bus.fetch_pc0};
    assign wdata1 = '{instr: bus.fetch_instr1, pc: bus.fetch_pc0 + XLEN'(4)};

    assign dec0 = decode(head0.instr[31:26], head0.instr[25:21], head0.instr[20:16], head0.instr[15:11]);
    assign dec1 = decode(head1.instr[31:26], head1.instr[25:21], head1.instr[20:16], head1.instr[15:11]);

    assign blk0_c = lu_blocked(dec0, bus.lu_memread1, bus.lu_dest1, bus.lu_memread2, bus.lu_dest2);
    assign blk1_c = lu_blocked(dec1, bus.lu_memread1, bus.lu_dest1, bus.lu_memread2, bus.lu_dest2);

    // Younger may join older: no RAW on older dest, no WAW, one memory op, no control flow
    always_comb begin
        logic raw, waw;
        raw = (dec0.dest != '0) &&
              ((dec1.use1 && (dec1.src1 == dec0.dest)) || (dec1.use2 && (dec1.src2 == dec0.dest)));
        waw = (dec0.dest != '0) && (dec1.dest == dec0.dest);
        pair_ok_c = !raw && !waw && !(dec0.is_mem && dec1.is_mem) && !dec0.is_ctrl && !dec1.is_ctrl;
    end

    assign ready_c = (count <= CNT_W'(2)) && (state_q != ST_FLUSH);

    // Next state, push/pop and issue-register decision; flush dominates
    always_comb begin
        state_d  = state_q;
        valid1_d = valid1_q;
        valid2_d = valid2_q;
        instr1_d = instr1_q;
        instr2_d = instr2_q;
        pc1_d    = pc1_q;
        pc2_d    = pc2_q;
        push_n   = 2'd0;
        pop_n    = 2'd0;
        clear    = 1'b0;
        slot1_c  = (state_q == ST_RUN) && (count != '0) && !bus.id_stall && !blk0_c && !bus.flush;
        slot2_c  = slot1_c && (count >= CNT_W'(2)) && !blk1_c && pair_ok_c;
        if (bus.flush) begin
            state_d  = ST_FLUSH;
            clear    = 1'b1;
            valid1_d = 1'b0;
            valid2_d = 1'b0;
        end else begin
            if (ready_c && bus.fetch_valid0) push_n = bus.fetch_valid1 ? 2'd2 : 2'd1;
            pop_n = {1'b0, slot1_c} + {1'b0, slot2_c};
            case (state_q)
                ST_RUN:      if ((count != '0) && blk0_c && !bus.id_stall) state_d = ST_LU_STALL;
                ST_LU_STALL: state_d = ST_RUN;
                ST_FLUSH:    state_d = ST_RUN;
                default:     state_d = ST_RUN;
            endcase
            if (!bus.id_stall) begin
                valid1_d = slot1_c;
                valid2_d = slot2_c;
                instr1_d = slot1_c ? head0.instr : '0;
                pc1_d    = slot1_c ? head0.pc    : '0;
                instr2_d = slot2_c ? head1.instr : '0;
                pc2_d    = slot2_c ? head1.pc    : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            instr1_q <= '0;
            instr2_q <= '0;
            pc1_q    <= '0;
            pc2_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid1_q <= valid1_d;
            valid2_q <= valid2_d;
            instr1_q <= instr1_d;
            instr2_q <= instr2_d;
            pc1_q    <= pc1_d;
            pc2_q    <= pc2_d;
        end
    end

    assign bus.fetch_ready  = ready_c;
    assign bus.issue_valid1 = valid1_q;
    assign bus.issue_valid2 = valid2_q;
    assign bus.issue_instr1 = instr1_q;
    assign bus.issue_instr2 = instr2_q;
    assign bus.issue_pc1    = pc1_q;
    assign bus.issue_pc2    = pc2_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: table of per-cycle vectors plus
// hand-written flush, stall/wrap and mid-run reset sequences.
module tb_issue_scheduler;
    import dual_issue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_scheduler_if bus();

    issue_scheduler u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        fv0, fv1;
        logic [31:0] i0, i1, pc0;
        logic        lum1;
        logic [4:0]  lud1;
        logic        lum2;
        logic [4:0]  lud2;
        logic        e_ready;
        logic        e_v1;
        logic [31:0] e_i1, e_pc1;
        logic        e_v2;
        logic [31:0] e_i2, e_pc2;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    localparam logic        Y  = 1'b1;
    localparam logic        N  = 1'b0;
    localparam logic [4:0]  R0 = 5'd0;
    localparam logic [31:0] Z  = 32'h0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.fetch_valid0 = 1'b0;
        bus.fetch_valid1 = 1'b0;
        bus.fetch_instr0 = '0;
        bus.fetch_instr1 = '0;
        bus.fetch_pc0    = '0;
        bus.id_stall     = 1'b0;
        bus.flush        = 1'b0;
        bus.lu_memread1  = 1'b0;
        bus.lu_memread2  = 1'b0;
        bus.lu_dest1     = '0;
        bus.lu_dest2     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        logic [31:0] a, b, c, lw_i, sw_i, bq, d, e, f, g, k, w1, w2, z1, z2;
        logic [31:0] s [6];
        logic [31:0] r [4];
        logic [63:0] got [$];
        logic [63:0] gv;
        int pi;

        a    = rtype(5'd2, 5'd3, 5'd1, FN_ADD);    // add $1,$2,$3
        b    = rtype(5'd5, 5'd6, 5'd4, FN_ADD);    // add $4,$5,$6
        c    = rtype(5'd1, 5'd5, 5'd4, FN_SUB);    // sub $4,$1,$5
        lw_i = itype(OP_LW, 5'd3, 5'd2, 16'd0);    // lw $2,0($3)
        sw_i = itype(OP_SW, 5'd5, 5'd4, 16'd0);    // sw $4,0($5)
        bq   = itype(OP_BEQ, 5'd1, 5'd2, 16'd3);   // beq $1,$2,3
        d    = rtype(5'd8, 5'd9, 5'd7, FN_ADD);    // add $7,$8,$9
        e    = rtype(5'd8, 5'd1, 5'd9, FN_ADD);    // add $9,$8,$1
        f    = itype(OP_ADDI, 5'd11, 5'd10, 16'd5);// addi $10,$11,5
        g    = itype(OP_ADDI, 5'd13, 5'd12, 16'd1);// addi $12,$13,1
        k    = rtype(5'd0, 5'd16, 5'd15, FN_ADD);  // add $15,$0,$16
        w1   = rtype(5'd2, 5'd3, 5'd20, FN_ADD);   // add $20,$2,$3
        w2   = rtype(5'd4, 5'd5, 5'd20, FN_OR);    // or  $20,$4,$5
        z1   = rtype(5'd2, 5'd3, 5'd0, FN_ADD);    // add $0,$2,$3
        z2   = rtype(5'd0, 5'd5, 5'd0, FN_AND);    // and $0,$0,$5
        for (int i = 0; i < 6; i++) s[i] = rtype(5'd0, 5'd0, 5'(i + 1), FN_ADD);
        for (int i = 0; i < 4; i++) r[i] = rtype(5'd0, 5'd0, 5'(i + 21), FN_SLT);

        //            fv0 fv1 i0    i1  pc0       lum1 lud1  lum2 lud2   rdy v1 i1   pc1       v2 i2  pc2
        vecs[0]  = '{Y, Y, a,    b,  32'h100, N, R0,   N, R0,    Y, N, Z,    Z,       N, Z,  Z};
        vecs[1]  = '{Y, Y, a,    c,  32'h200, N, R0,   N, R0,    Y, Y, a,    32'h100, Y, b,  32'h104};
        vecs[2]  = '{N, N, Z,    Z,  Z,       N, R0,   N, R0,    Y, Y, a,    32'h200, N, Z,  Z};
        vecs[3]  = '{Y, Y, lw_i, sw_i, 32'h300, N, R0, N, R0,    Y, Y, c,    32'h204, N, Z,  Z};
        vecs[4]  = '{Y, Y, bq,   d,  32'h400, N, R0,   N, R0,    N, Y, lw_i, 32'h300, N, Z,  Z};
        vecs[5]  = '{N, N, Z,    Z,  Z,       N, R0,   N, R0,    Y, Y, sw_i, 32'h304, N, Z,  Z};
        vecs[6]  = '{N, N, Z,    Z,  Z,       N, R0,   N, R0,    Y, Y, bq,   32'h400, N, Z,  Z};
        vecs[7]  = '{N, N, Z,    Z,  Z,       N, R0,   N, R0,    Y, Y, d,    32'h404, N, Z,  Z};
        vecs[8]  = '{Y, N, e,    Z,  32'h500, Y, 5'd8, N, R0,    Y, N, Z,    Z,       N, Z,  Z};
        vecs[9]  = '{N, N, Z,    Z,  Z,       Y, 5'd8, N, R0,    Y, N, Z,    Z,       N, Z,  Z};
        vecs[10] = '{N, N, Z,    Z,  Z,       N, R0,   N, R0,    Y, N, Z,    Z,       N, Z,  Z};
        vecs[11] = '{N, N, Z,    Z,  Z,       N, R0,   N, R0,    Y, Y, e,    32'h500, N, Z,  Z};
        vecs[12] = '{Y, N, f,    Z,  32'h600, N, R0,   Y, 5'd11, Y, N, Z,    Z,       N, Z,  Z};
        vecs[13] = '{N, N, Z,    Z,  Z,       N, R0,   Y, 5'd11, Y, N, Z,    Z,       N, Z,  Z};
        vecs[14] = '{N, N, Z,    Z,  Z,       N, R0,   N, R0,    Y, N, Z,    Z,       N, Z,  Z};
        vecs[15] = '{N, N, Z,    Z,  Z,       N, R0,   N, R0,    Y, Y, f,    32'h600, N, Z,  Z};
        vecs[16] = '{Y, N, g,    Z,  32'h700, Y, 5'd12, N, R0,   Y, N, Z,    Z,       N, Z,  Z};
        vecs[17] = '{N, N, Z,    Z,  Z,       Y, 5'd12, N, R0,   Y, Y, g,    32'h700, N, Z,  Z};
        vecs[18] = '{Y, N, k,    Z,  32'h800, Y, R0,   N, R0,    Y, N, Z,    Z,       N, Z,  Z};
        vecs[19] = '{N, N, Z,    Z,  Z,       Y, R0,   N, R0,    Y, Y, k,    32'h800, N, Z,  Z};
        vecs[20] = '{Y, Y, w1,   w2, 32'h900, N, R0,   N, R0,    Y, N, Z,    Z,       N, Z,  Z};
        vecs[21] = '{N, N, Z,    Z,  Z,       N, R0,   N, R0,    Y, Y, w1,   32'h900, N, Z,  Z};
        vecs[22] = '{N, N, Z,    Z,  Z,       N, R0,   N, R0,    Y, Y, w2,   32'h904, N, Z,  Z};
        vecs[23] = '{Y, Y, z1,   z2, 32'hA00, N, R0,   N, R0,    Y, N, Z,    Z,       N, Z,  Z};
        vecs[24] = '{N, N, Z,    Z,  Z,       N, R0,   N, R0,    Y, Y, z1,   32'hA00, Y, z2, 32'hA04};

        // Reset values
        idle();
        rst = 1'b0;
        #12;
        check1("rst v1", bus.issue_valid1, 1'b0);
        check1("rst v2", bus.issue_valid2, 1'b0);
        check32("rst instr1", bus.issue_instr1, 32'h0);
        check32("rst pc2", bus.issue_pc2, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check1("post-rst ready", bus.fetch_ready, 1'b1);

        // Table-driven cycles
        for (int i = 0; i < NV; i++) begin
            idle();
            bus.fetch_valid0 = vecs[i].fv0;
            bus.fetch_valid1 = vecs[i].fv1;
            bus.fetch_instr0 = vecs[i].i0;
            bus.fetch_instr1 = vecs[i].i1;
            bus.fetch_pc0    = vecs[i].pc0;
            bus.lu_memread1  = vecs[i].lum1;
            bus.lu_dest1     = vecs[i].lud1;
            bus.lu_memread2  = vecs[i].lum2;
            bus.lu_dest2     = vecs[i].lud2;
            tick();
            check1($sformatf("row%0d ready", i), bus.fetch_ready, vecs[i].e_ready);
            check1($sformatf("row%0d v1", i), bus.issue_valid1, vecs[i].e_v1);
            check1($sformatf("row%0d v2", i), bus.issue_valid2, vecs[i].e_v2);
            if (vecs[i].e_v1) begin
                check32($sformatf("row%0d instr1", i), bus.issue_instr1, vecs[i].e_i1);
                check32($sformatf("row%0d pc1", i), bus.issue_pc1, vecs[i].e_pc1);
            end
            if (vecs[i].e_v2) begin
                check32($sformatf("row%0d instr2", i), bus.issue_instr2, vecs[i].e_i2);
                check32($sformatf("row%0d pc2", i), bus.issue_pc2, vecs[i].e_pc2);
            end
        end

        // Flush with three buffered entries and a same-cycle fetch
        idle();
        bus.id_stall = 1'b1;
        bus.fetch_valid0 = 1'b1; bus.fetch_valid1 = 1'b1;
        bus.fetch_instr0 = s[0]; bus.fetch_instr1 = s[1]; bus.fetch_pc0 = 32'hC00;
        tick();
        check1("stall hold v1", bus.issue_valid1, 1'b1);
        check32("stall hold instr1", bus.issue_instr1, z1);
        idle();
        bus.id_stall = 1'b1;
        bus.fetch_valid0 = 1'b1; bus.fetch_instr0 = s[2]; bus.fetch_pc0 = 32'hC08;
        tick();
        check1("fl count3 ready", bus.fetch_ready, 1'b0);
        idle();
        bus.flush = 1'b1; bus.id_stall = 1'b1;
        bus.fetch_valid0 = 1'b1; bus.fetch_instr0 = s[3]; bus.fetch_pc0 = 32'hD00;
        tick();
        check1("flush v1", bus.issue_valid1, 1'b0);
        check1("flush v2", bus.issue_valid2, 1'b0);
        check1("flush state ready", bus.fetch_ready, 1'b0);
        idle();
        bus.fetch_valid0 = 1'b1; bus.fetch_instr0 = s[4]; bus.fetch_pc0 = 32'hD10;
        tick();
        check1("after flush ready", bus.fetch_ready, 1'b1);
        check1("after flush v1", bus.issue_valid1, 1'b0);
        idle();
        bus.flush = 1'b1;
        bus.fetch_valid0 = 1'b1; bus.fetch_instr0 = s[5]; bus.fetch_pc0 = 32'hD20;
        tick();
        check1("flush2 ready", bus.fetch_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            tick();
            check1($sformatf("flush drain%0d v1", i), bus.issue_valid1, 1'b0);
            check1($sformatf("flush drain%0d ready", i), bus.fetch_ready, 1'b1);
        end

        // Six instructions under id_stall, then drain in order across pointer wrap
        idle();
        bus.id_stall = 1'b1;
        bus.fetch_valid0 = 1'b1; bus.fetch_valid1 = 1'b1;
        bus.fetch_instr0 = s[0]; bus.fetch_instr1 = s[1]; bus.fetch_pc0 = 32'hB00;
        tick();
        check1("wrap c2 ready", bus.fetch_ready, 1'b1);
        idle();
        bus.id_stall = 1'b1;
        bus.fetch_valid0 = 1'b1; bus.fetch_instr0 = s[2]; bus.fetch_pc0 = 32'hB08;
        tick();
        check1("wrap c3 ready", bus.fetch_ready, 1'b0);
        check1("wrap stalled v1", bus.issue_valid1, 1'b0);
        pi = 3;
        for (int cyc = 0; cyc < 20 && got.size() < 6; cyc++) begin
            idle();
            if (bus.fetch_ready && pi < 6) begin
                bus.fetch_valid0 = 1'b1;
                bus.fetch_instr0 = s[pi];
                bus.fetch_pc0    = 32'hB00 + 32'(4 * pi);
                if (pi < 5) begin
                    bus.fetch_valid1 = 1'b1;
                    bus.fetch_instr1 = s[pi + 1];
                    pi += 2;
                end else begin
                    pi += 1;
                end
            end
            tick();
            if (bus.issue_valid1) got.push_back({bus.issue_pc1, bus.issue_instr1});
            if (bus.issue_valid2) got.push_back({bus.issue_pc2, bus.issue_instr2});
        end
        check32("wrap issued count", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            gv = (i < got.size()) ? got[i] : 64'hFFFF_FFFF_FFFF_FFFF;
            check32($sformatf("wrap instr%0d", i), gv[31:0], s[i]);
            check32($sformatf("wrap pc%0d", i), gv[63:32], 32'hB00 + 32'(4 * i));
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            tick();
            check1($sformatf("wrap idle%0d v1", i), bus.issue_valid1, 1'b0);
        end

        // Reset in the middle of operation drops buffered work
        idle();
        bus.fetch_valid0 = 1'b1; bus.fetch_valid1 = 1'b1;
        bus.fetch_instr0 = r[0]; bus.fetch_instr1 = r[1]; bus.fetch_pc0 = 32'hE00;
        tick();
        idle();
        bus.fetch_valid0 = 1'b1; bus.fetch_valid1 = 1'b1;
        bus.fetch_instr0 = r[2]; bus.fetch_instr1 = r[3]; bus.fetch_pc0 = 32'hE08;
        tick();
        check32("pre-rst instr1", bus.issue_instr1, r[0]);
        check32("pre-rst instr2", bus.issue_instr2, r[1]);
        idle();
        bus.id_stall = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check1("async rst v1", bus.issue_valid1, 1'b0);
        check1("async rst v2", bus.issue_valid2, 1'b0);
        check32("async rst pc1", bus.issue_pc1, 32'h0);
        check1("async rst ready", bus.fetch_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check1($sformatf("post-rst%0d v1", i), bus.issue_valid1, 1'b0);
            check1($sformatf("post-rst%0d v2", i), bus.issue_valid2, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001: clk  in  1  pipeline clock, all state on rising edge.
REQ-002: rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003: fetch_valid0, fetch_valid1  in  1 each  fetched instr 0 (older) / 1 (younger) present; fetch_valid1 implies fetch_valid0.
REQ-004: fetch_instr0, fetch_instr1  in  32 each  MIPS instruction words.
REQ-005: fetch_pc0  in  32  PC of instr0; instr1 PC = fetch_pc0+4.
REQ-006: fetch_ready  out  1  buffer can accept two instructions this cycle.
REQ-007: id_stall  in  1  downstream backpressure; hold issue registers.
REQ-008: flush  in  1  branch/jump redirect; discard all buffered and issued instructions.
REQ-009: lu_memread1, lu_memread2  in  1 each  load in the stage directly ahead of the issue registers, lane 1 / lane 2.
REQ-010: lu_dest1, lu_dest2  in  5 each  destination register of those loads.
REQ-011: issue_valid1, issue_valid2  out  1 each  slot 1 (older) / slot 2 carries an instruction.
REQ-012: issue_instr1, issue_instr2, issue_pc1, issue_pc2  out  32 each  issued words and PCs, registered.

Function
REQ-013: Buffer SHALL be a 4-entry circular FIFO; 2-bit rd/wr pointers wrap 3->0; count 0..4.
REQ-014: fetch_ready SHALL be 1 iff registered count <= 2 and state != FLUSH.
REQ-015: Push when fetch_ready and fetch_valid0: 1 or 2 entries in order; same-cycle push and pop allowed.
REQ-016: Decode per entry: op 0 -> dest rd, srcs rs,rt; addi/andi/ori/slti -> dest rt, src rs; lw -> dest rt, src rs, load; sw -> no dest, srcs rs,rt, store; beq/bne -> no dest, srcs rs,rt, branch; j/jal -> jump (jal dest 31); dest 0 is treated as no dest.
REQ-017: Head entry SHALL be load-use blocked if any used source is nonzero and equals lu_destN with lu_memreadN=1 (N=1,2).
REQ-018: Slot 1 issues head iff state=RUN, count>=1, id_stall=0, head not blocked.
REQ-019: Slot 2 issues head+1 iff slot 1 issues, count>=2, head+1 not blocked, no head+1 source equal to head dest, dests differ, not both load/store, head not branch/jump, head+1 not branch/jump.
REQ-020: Issue registers SHALL load the decision at the clock edge; latency fetch->issue outputs = 2 edges minimum; pop count equals issued count.
REQ-021: id_stall=1: issue registers and rd pointer hold; push still permitted.
REQ-022: FSM states RUN, LU_STALL, FLUSH. RUN->LU_STALL when head blocked and id_stall=0 (issue registers load valid=0); LU_STALL->RUN next cycle unconditionally.
REQ-023: Any state ->FLUSH when flush=1: count, pointers cleared; issue_valid1/2 cleared; same-cycle fetch discarded. FLUSH->RUN next cycle unless flush=1.
REQ-024: flush has priority over id_stall, push and issue.

Reset
REQ-025: rst=0 SHALL asynchronously clear pointers, count, state=RUN, issue_valid1/2=0, issue_instr/pc=0; fetch_ready=1 after release.
REQ-026: Reset mid-operation SHALL drop all buffered instructions without issuing them.

Structure
REQ-027: Shared package dual_issue_pkg holds opcode/funct constants, FSM state enum, buffer depth constant (4).
REQ-028: FIFO storage and pointers SHALL be sub-module instr_buffer; decode, pairing, FSM stay in issue_scheduler.

Verification
REQ-029: add $1,$2,$3 + add $4,$5,$6 pushed together -> both issue same cycle, issue_valid1=issue_valid2=1.
REQ-030: add $1,$2,$3 + sub $4,$1,$5 -> add alone in slot 1; sub in slot 1 next cycle.
REQ-031: lu_memread1=1, lu_dest1=8, head add $9,$8,$1 -> one bubble (valid=0), state LU_STALL, add issues following cycle.
REQ-032: lw $2,0($3) + sw $4,0($5) -> split across two cycles; beq in head -> issues alone.
REQ-033: 3 entries buffered, flush=1 with fetch_valid0=1 -> count 0, issue_valid 0, fetched instr never issued.
REQ-034: Push 6 instrs with id_stall=1 -> fetch_ready falls at count 3; deassert -> all 6 issue in order, pointers wrap correctly.
